// File: rtl/row_sparse_encoder_pkg.sv
// Shared definitions for the row sparse encoder and other stream FSMs:
// width helper, default geometry and the common state encoding.
package row_sparse_encoder_pkg;

    function automatic int unsigned c_log_2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_IF_WIDTH   = 34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLAG = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/row_sparse_encoder_first_one_finder.sv
// Combinational priority encoder: lowest set index, exactly-one-set and any-set.
module first_one_finder
    import row_sparse_encoder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_IF_WIDTH,
    parameter int unsigned IDX_WIDTH = c_log_2(WIDTH)
) (
    input  logic [WIDTH-1:0]     vec,
    output logic [IDX_WIDTH-1:0] idx_c,
    output logic                 one_hot_c,
    output logic                 any_c
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        idx_c = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c = IDX_WIDTH'(i);
            end
        end
        any_c     = |vec;
        one_hot_c = any_c && ((vec & (vec - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/row_sparse_encoder.sv
// Dense row -> sparse stream: one nonzero-flag word, then the nonzero values
// in column order. One row in flight at a time.
module row_sparse_encoder
    import row_sparse_encoder_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned IF_WIDTH   = DEF_IF_WIDTH,
    localparam int unsigned ROW_WIDTH  = DATA_WIDTH * IF_WIDTH,
    localparam int unsigned CNT_WIDTH  = c_log_2(IF_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [ROW_WIDTH-1:0]  row_data,
    output logic                  flag_valid,
    input  logic                  flag_ready,
    output logic [IF_WIDTH-1:0]   flag_out,
    output logic [CNT_WIDTH-1:0]  flag_nnz,
    output logic                  val_valid,
    input  logic                  val_ready,
    output logic [DATA_WIDTH-1:0] val_data,
    output logic                  val_last
);

    localparam int unsigned IDX_WIDTH = c_log_2(IF_WIDTH);

    state_t                  state, state_nxt;
    logic [ROW_WIDTH-1:0]    row_q, row_nxt;
    logic [IF_WIDTH-1:0]     mask_q, mask_nxt;
    logic [IF_WIDTH-1:0]     flag_in_c, flag_out_nxt;
    logic [CNT_WIDTH-1:0]    nnz_in_c, flag_nnz_nxt;
    logic [IDX_WIDTH-1:0]    idx_c;
    logic                    one_hot_c, any_c;
    logic [DATA_WIDTH-1:0]   val_data_nxt;
    logic                    val_last_nxt;
    logic                    val_valid_nxt;

    // Per-column nonzero flags and their popcount for the offered row.
    always_comb begin
        flag_in_c = '0;
        nnz_in_c  = '0;
        for (int i = 0; i < int'(IF_WIDTH); i++) begin
            flag_in_c[i] = |row_data[ROW_WIDTH - 1 - i * DATA_WIDTH -: DATA_WIDTH];
            nnz_in_c     = nnz_in_c + CNT_WIDTH'(flag_in_c[i]);
        end
    end

    // Next state; the whole FSM holds when clk_en is low.
    always_comb begin
        state_nxt    = state;
        row_nxt      = row_q;
        mask_nxt     = mask_q;
        flag_out_nxt = flag_out;
        flag_nnz_nxt = flag_nnz;
        if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (row_valid) begin
                        row_nxt      = row_data;
                        flag_out_nxt = flag_in_c;
                        flag_nnz_nxt = nnz_in_c;
                        mask_nxt     = flag_in_c;
                        state_nxt    = ST_FLAG;
                    end
                end
                ST_FLAG: begin
                    if (flag_ready) begin
                        state_nxt = (flag_nnz == '0) ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (val_ready) begin
                        mask_nxt = mask_q & (mask_q - IF_WIDTH'(1));
                        if (val_last) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Value outputs are precomputed from the next mask so they can be registered.
    first_one_finder #(
        .WIDTH     (IF_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_first_one (
        .vec       (mask_nxt),
        .idx_c     (idx_c),
        .one_hot_c (one_hot_c),
        .any_c     (any_c)
    );

    always_comb begin
        val_valid_nxt = (state_nxt == ST_DATA) && any_c;
        val_data_nxt  = '0;
        val_last_nxt  = 1'b0;
        if (val_valid_nxt) begin
            val_data_nxt = row_nxt[ROW_WIDTH - 1 - DATA_WIDTH * 32'(idx_c) -: DATA_WIDTH];
            val_last_nxt = one_hot_c;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            row_q      <= '0;
            mask_q     <= '0;
            row_ready  <= 1'b1;
            flag_valid <= 1'b0;
            flag_out   <= '0;
            flag_nnz   <= '0;
            val_valid  <= 1'b0;
            val_data   <= '0;
            val_last   <= 1'b0;
        end else begin
            state      <= state_nxt;
            row_q      <= row_nxt;
            mask_q     <= mask_nxt;
            row_ready  <= (state_nxt == ST_IDLE);
            flag_valid <= (state_nxt == ST_FLAG);
            flag_out   <= flag_out_nxt;
            flag_nnz   <= flag_nnz_nxt;
            val_valid  <= val_valid_nxt;
            val_data   <= val_data_nxt;
            val_last   <= val_last_nxt;
        end
    end

endmodule

// File: doc/row_sparse_encoder.md
# row_sparse_encoder

Write-side counterpart of the cache-row reader path. Accepts one dense feature-map row of IF_WIDTH columns per handshake and emits it in sparse form. Output is a per-column nonzero flag word followed by the nonzero values in column order. The flag/value streams are the same format the sparsity/column sources consume, so output rows can be written back to on-chip memory compressed.

## Interface
- DATA_WIDTH, 8, bits per element
- IF_WIDTH, 34, columns per row
- ROW_WIDTH, DATA_WIDTH*IF_WIDTH, dense row width (derived)
- CNT_WIDTH, C_LOG_2(IF_WIDTH+1), nonzero-count width (6 for defaults)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- clk_en  in  1  global clock enable; all state and handshakes frozen when 0
- row_valid  in  1  dense row offered
- row_ready  out  1  encoder can accept a row
- row_data  in  ROW_WIDTH  dense row; column i = row_data[ROW_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH] (column 0 in MSBs)
- flag_valid  out  1  flag word available
- flag_ready  in  1  flag sink accepts
- flag_out  out  IF_WIDTH  bit i = 1 iff column i nonzero
- flag_nnz  out  CNT_WIDTH  popcount of flag_out
- val_valid  out  1  nonzero value available
- val_ready  in  1  value sink accepts
- val_data  out  DATA_WIDTH  current nonzero value
- val_last  out  1  val_data is final nonzero of the row

## Operation
- Handshake on any channel completes on a rising clk edge with valid=1, ready=1, clk_en=1.
- FSM states: IDLE, FLAG, DATA.
- IDLE: row_ready=1. On row handshake: latch row_data into row register, compute flag_out and flag_nnz from it, copy flag_out into remaining-mask register, go FLAG.
- FLAG: flag_valid=1, flag_out/flag_nnz held stable. On flag handshake: if flag_nnz==0 go IDLE, else go DATA.
- DATA: val_valid=1. val_data = column at lowest set bit index of remaining-mask. val_last=1 iff remaining-mask has exactly one bit set. On val handshake: clear that bit; if val_last go IDLE, else stay in DATA.
- Element is zero iff all DATA_WIDTH bits are 0; no signed interpretation.
- row_ready=0 in FLAG and DATA. No overlap between rows.
- valid outputs never drop, and their data never changes, until the handshake completes (AXI-style stability), including when clk_en=0.
- Reset, including mid-row: FSM→IDLE, row and mask registers cleared, current row discarded.
- Reset values: row_ready=1, flag_valid=0, flag_out=0, flag_nnz=0, val_valid=0, val_data=0, val_last=0.

## Timing
- Row accepted at edge N: flag_valid=1 after edge N (cycle N+1).
- flag_ready held 1: first val_valid in the cycle after the flag handshake.
- val_ready held 1: one value per cycle, no bubbles.
- Row with k≥1 nonzeros, sinks always ready: k+2 cycles per row (accept, flag, k values). All-zero row: 2 cycles.
- row_ready is a registered function of state only; no combinational path from any input to any ready/valid.
- clk_en=0 stretches every state by the number of disabled cycles.

## Structure
- Shared header cnn_defs.vh holds:
  - the C_LOG_2 macro
  - DATA_WIDTH/IF_WIDTH defaults
  - state encodings (IDLE=2'd0, FLAG=2'd1, DATA=2'd2), shared with other stream FSMs
- One sub-module: first_one_finder, a parameterised combinational priority encoder over IF_WIDTH bits. Outputs: lowest-set index (C_LOG_2(IF_WIDTH) bits), a one-hot-minus-one flag (exactly one bit set), and any-set.
- Popcount is inline combinational logic in the top.

## Test plan
- All-zero row, sinks ready → flag_out=0, flag_nnz=0, no val_valid; row_ready=1 again 2 cycles after acceptance.
- Row with col0=0x11, col5=0x22, col33=0x33, rest 0 → flag_out bits {0,5,33}=1, flag_nnz=3; values 0x11, 0x22, 0x33 on consecutive cycles; val_last only with 0x33.
- Dense row, column i = i+1 (0x01..0x22) → flag_out all ones, flag_nnz=34; 34 values 0x01..0x22; val_last only on 0x22; 36 cycles total.
- Same 3-value row with val_ready pattern 0,1,0,1,… and flag_ready delayed 3 cycles → flag_out and val_data stable while stalled; exactly 3 value handshakes, in order.
- clk_en=0 for 4 cycles mid-DATA → no state advance, outputs unchanged; sequence resumes with the next pending value.
- rst_n asserted during DATA after 1 of 3 values → all outputs at reset values immediately; after release row_ready=1. A new row then encodes correctly with no residue from the aborted row.
